// File: rtl/dpcm_pkg.sv
// Shared types and helpers for the DPCM reconstruction path.
package dpcm_pkg;

  typedef enum logic {
    ACCEPT  = 1'b0,
    PRESENT = 1'b1
  } dpcm_state_t;

  // Sample width shared with the difference encoder.
  localparam int DPCM_WIDTH_DEF = 8;

  // Clamp a signed value into the unsigned range [0, 2^width-1].
  // The caller keeps the low 'width' bits of the result.
  function automatic logic [31:0] clamp_u(input logic signed [31:0] value,
                                          input int unsigned width);
    logic signed [31:0] maxVal_s;
    maxVal_s = (32'sd1 <<< width) - 32'sd1;
    if (value < 32'sd0) begin
      clamp_u = 32'd0;
    end else if (value > maxVal_s) begin
      clamp_u = maxVal_s;
    end else begin
      clamp_u = value;
    end
  endfunction

endpackage

// File: rtl/dpcm_sat_add.sv
// Combinational prediction update: pred +/- mag, clamped to the sample range.
module dpcm_sat_add
  import dpcm_pkg::*;
#(
  parameter int WIDTH = DPCM_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] pred,
  input  logic [WIDTH-1:0] mag,
  input  logic             sign,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);

  // Two guard bits: one for the sign, one for the carry of pred + mag.
  logic signed [WIDTH+1:0] predExt_s;
  logic signed [WIDTH+1:0] magExt_s;
  logic signed [WIDTH+1:0] raw_s;
  logic signed [31:0]      rawWide_s;
  logic [31:0]             clamped_s;

  // Form the signed sum/difference and clamp it; any change by the clamp is a saturation.
  always_comb begin
    predExt_s = $signed({2'b00, pred});
    magExt_s  = $signed({2'b00, mag});
    if (sign) begin
      raw_s = predExt_s - magExt_s;
    end else begin
      raw_s = predExt_s + magExt_s;
    end
    rawWide_s = {{(32-WIDTH-2){raw_s[WIDTH+1]}}, raw_s};
    clamped_s = clamp_u(rawWide_s, WIDTH);
    sum       = clamped_s[WIDTH-1:0];
    sat       = (clamped_s != $unsigned(rawWide_s));
  end

endmodule

// File: rtl/dpcm_reconstruct.sv
// DPCM decoder: rebuilds absolute samples from sign+magnitude differences,
// with valid/ready handshakes on both sides and sticky saturation/key-loss flags.
module dpcm_reconstruct
  import dpcm_pkg::*;
#(
  parameter int WIDTH     = DPCM_WIDTH_DEF,
  parameter int FRAME_LEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             SignIn,
  input  logic             KeyIn,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] DataOut,
  output logic             SatFlag,
  output logic             KeyErr,
  output logic [15:0]      SampleCnt
);

  dpcm_state_t      state_r;
  logic [WIDTH-1:0] pred_r;

  logic             inXfer_s;
  logic             outXfer_s;
  logic [WIDTH-1:0] sum_s;
  logic             sat_s;
  logic [WIDTH-1:0] nextSample_s;
  logic             clampHit_s;
  logic             frameHit_s;
  logic [15:0]      nextCnt_s;

  dpcm_sat_add #(
    .WIDTH(WIDTH)
  ) u_satAdd (
    .pred(pred_r),
    .mag (DataIn),
    .sign(SignIn),
    .sum (sum_s),
    .sat (sat_s)
  );

  // Decode the candidate sample, counter step and flag events for an input transfer.
  always_comb begin
    inXfer_s  = InValid && InReady;
    outXfer_s = OutValid && OutReady;
    if (KeyIn) begin
      nextSample_s = DataIn;
      clampHit_s   = 1'b0;
      frameHit_s   = 1'b0;
      nextCnt_s    = 16'd0;
    end else begin
      nextSample_s = sum_s;
      clampHit_s   = sat_s;
      frameHit_s   = (FRAME_LEN != 0) && (SampleCnt == 16'(FRAME_LEN));
      if (SampleCnt == 16'hFFFF) begin
        nextCnt_s = 16'hFFFF;
      end else begin
        nextCnt_s = SampleCnt + 16'd1;
      end
    end
  end

  // Two-state handshake FSM; outputs, prediction, counter and sticky flags are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ACCEPT;
      InReady   <= 1'b1;
      OutValid  <= 1'b0;
      DataOut   <= {WIDTH{1'b0}};
      pred_r    <= {WIDTH{1'b0}};
      SatFlag   <= 1'b0;
      KeyErr    <= 1'b0;
      SampleCnt <= 16'd0;
    end else begin
      case (state_r)
        ACCEPT: begin
          if (inXfer_s) begin
            pred_r    <= nextSample_s;
            DataOut   <= nextSample_s;
            SampleCnt <= nextCnt_s;
            SatFlag   <= SatFlag | clampHit_s;
            KeyErr    <= KeyErr | frameHit_s;
            InReady   <= 1'b0;
            OutValid  <= 1'b1;
            state_r   <= PRESENT;
          end
        end
        PRESENT: begin
          if (outXfer_s) begin
            InReady  <= 1'b1;
            OutValid <= 1'b0;
            state_r  <= ACCEPT;
          end
        end
        default: begin
          InReady  <= 1'b1;
          OutValid <= 1'b0;
          state_r  <= ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpcm_reconstruct.sv
// Scoreboard bench for dpcm_reconstruct (FRAME_LEN=4 so key-loss is reachable quickly).
module tb_dpcm_reconstruct;

  typedef struct packed {
    logic [7:0]  data;
    logic        sat;
    logic        keyErr;
    logic [15:0] cnt;
  } expect_t;

  logic        clk;
  logic        rst;
  logic        InValid;
  logic        InReady;
  logic [7:0]  DataIn;
  logic        SignIn;
  logic        KeyIn;
  logic        OutValid;
  logic        OutReady;
  logic [7:0]  DataOut;
  logic        SatFlag;
  logic        KeyErr;
  logic [15:0] SampleCnt;

  expect_t scoreQ[$];
  expect_t monE;
  int      compared;
  int      mismatched;
  int      popped;
  bit      stopToggle;

  dpcm_reconstruct #(
    .WIDTH    (8),
    .FRAME_LEN(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .DataIn   (DataIn),
    .SignIn   (SignIn),
    .KeyIn    (KeyIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .DataOut  (DataOut),
    .SatFlag  (SatFlag),
    .KeyErr   (KeyErr),
    .SampleCnt(SampleCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic expect_t mk(input logic [7:0] d, input logic s, input logic k,
                                 input logic [15:0] c);
    expect_t e;
    e.data = d; e.sat = s; e.keyErr = k; e.cnt = c;
    return e;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: an output transfer happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (!rst && OutValid && OutReady) begin
      compared++;
      if (scoreQ.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_output: got DataOut=%0d with nothing expected", DataOut);
      end else begin
        monE = scoreQ.pop_front();
        popped++;
        if (DataOut !== monE.data || SatFlag !== monE.sat || KeyErr !== monE.keyErr ||
            SampleCnt !== monE.cnt) begin
          mismatched++;
          $display("FAIL sample: got data=%0d sat=%0b keyErr=%0b cnt=%0d expected data=%0d sat=%0b keyErr=%0b cnt=%0d",
                   DataOut, SatFlag, KeyErr, SampleCnt, monE.data, monE.sat, monE.keyErr, monE.cnt);
        end
      end
    end
  end

  task automatic sendSample(input logic [7:0] d, input logic s, input logic k, input expect_t e);
    int waitCnt;
    waitCnt = 0;
    InValid = 1'b1; DataIn = d; SignIn = s; KeyIn = k;
    while (!InReady && waitCnt < 200) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!InReady) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got InReady=0 after %0d cycles expected 1", waitCnt);
      InValid = 1'b0;
    end else begin
      scoreQ.push_back(e);
      @(posedge clk); #1;
      InValid = 1'b0;
    end
  endtask

  task automatic drain();
    int waitCnt;
    waitCnt = 0;
    while (scoreQ.size() != 0 && waitCnt < 100) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkVal("drain_pending", scoreQ.size(), 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    InValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    scoreQ.delete();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [7:0]  mPred;
  logic        mSat;
  logic        mKe;
  logic [15:0] mCnt;
  logic [7:0]  rD;
  logic        rS;
  logic        rK;
  int          sum;
  int          poppedStart;

  initial begin
    compared = 0; mismatched = 0; popped = 0; stopToggle = 1'b0;
    rst = 1'b1; InValid = 1'b0; DataIn = 8'd0; SignIn = 1'b0; KeyIn = 1'b0; OutReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset_InReady", InReady, 1);
    checkVal("reset_OutValid", OutValid, 0);
    checkVal("reset_DataOut", DataOut, 0);
    checkVal("reset_SatFlag", SatFlag, 0);
    checkVal("reset_KeyErr", KeyErr, 0);
    checkVal("reset_SampleCnt", SampleCnt, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic decode
    sendSample(8'd100, 1'b0, 1'b1, mk(8'd100, 1'b0, 1'b0, 16'd0));
    sendSample(8'd20,  1'b0, 1'b0, mk(8'd120, 1'b0, 1'b0, 16'd1));
    sendSample(8'd50,  1'b1, 1'b0, mk(8'd70,  1'b0, 1'b0, 16'd2));
    drain();

    // Saturation
    doReset();
    sendSample(8'd250, 1'b0, 1'b1, mk(8'd250, 1'b0, 1'b0, 16'd0));
    sendSample(8'd10,  1'b0, 1'b0, mk(8'd255, 1'b1, 1'b0, 16'd1));
    sendSample(8'd5,   1'b1, 1'b0, mk(8'd250, 1'b1, 1'b0, 16'd2));
    sendSample(8'd3,   1'b0, 1'b1, mk(8'd3,   1'b1, 1'b0, 16'd0));
    sendSample(8'd7,   1'b1, 1'b0, mk(8'd0,   1'b1, 1'b0, 16'd1));
    drain();
    doReset();
    sendSample(8'd245, 1'b0, 1'b1, mk(8'd245, 1'b0, 1'b0, 16'd0));
    sendSample(8'd10,  1'b0, 1'b0, mk(8'd255, 1'b0, 1'b0, 16'd1));
    sendSample(8'd7,   1'b0, 1'b1, mk(8'd7,   1'b0, 1'b0, 16'd0));
    sendSample(8'd7,   1'b1, 1'b0, mk(8'd0,   1'b0, 1'b0, 16'd1));
    sendSample(8'd0,   1'b1, 1'b0, mk(8'd0,   1'b0, 1'b0, 16'd2));
    drain();

    // Backpressure
    doReset();
    OutReady = 1'b0;
    sendSample(8'd50, 1'b0, 1'b1, mk(8'd50, 1'b0, 1'b0, 16'd0));
    InValid = 1'b1; DataIn = 8'd5; SignIn = 1'b0; KeyIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkVal("bp_OutValid", OutValid, 1);
      checkVal("bp_DataOut", DataOut, 50);
      checkVal("bp_InReady", InReady, 0);
      @(posedge clk); #1;
    end
    OutReady = 1'b1;
    @(posedge clk); #1;
    checkVal("release_InReady", InReady, 1);
    checkVal("release_OutValid", OutValid, 0);
    scoreQ.push_back(mk(8'd55, 1'b0, 1'b0, 16'd1));
    @(posedge clk); #1;
    InValid = 1'b0;
    checkVal("release_taken", OutValid, 1);
    drain();

    // Key-loss detection
    doReset();
    sendSample(8'd10, 1'b0, 1'b1, mk(8'd10, 1'b0, 1'b0, 16'd0));
    sendSample(8'd1,  1'b0, 1'b0, mk(8'd11, 1'b0, 1'b0, 16'd1));
    sendSample(8'd1,  1'b0, 1'b0, mk(8'd12, 1'b0, 1'b0, 16'd2));
    sendSample(8'd1,  1'b0, 1'b0, mk(8'd13, 1'b0, 1'b0, 16'd3));
    sendSample(8'd1,  1'b0, 1'b0, mk(8'd14, 1'b0, 1'b0, 16'd4));
    sendSample(8'd1,  1'b0, 1'b0, mk(8'd15, 1'b0, 1'b1, 16'd5));
    sendSample(8'd0,  1'b0, 1'b1, mk(8'd0,  1'b0, 1'b1, 16'd0));
    drain();

    // Asynchronous reset while a sample is presented
    doReset();
    OutReady = 1'b0;
    sendSample(8'd77, 1'b0, 1'b1, mk(8'd77, 1'b0, 1'b0, 16'd0));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkVal("arst_OutValid", OutValid, 0);
    checkVal("arst_DataOut", DataOut, 0);
    checkVal("arst_InReady", InReady, 1);
    scoreQ.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    OutReady = 1'b1;
    sendSample(8'd30, 1'b0, 1'b0, mk(8'd30, 1'b0, 1'b0, 16'd1));
    drain();

    // Random stream against a reference model
    doReset();
    mPred = 8'd0; mSat = 1'b0; mKe = 1'b0; mCnt = 16'd0;
    poppedStart = popped;
    stopToggle = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          rK = ($urandom_range(0, 7) == 0);
          rS = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) rD = 8'($urandom_range(0, 255));
          else rD = 8'($urandom_range(0, 15));
          if (rK) begin
            mPred = rD;
            mCnt  = 16'd0;
          end else begin
            if (mCnt == 16'd4) mKe = 1'b1;
            sum = rS ? (int'(mPred) - int'(rD)) : (int'(mPred) + int'(rD));
            if (sum < 0) begin
              mPred = 8'd0; mSat = 1'b1;
            end else if (sum > 255) begin
              mPred = 8'd255; mSat = 1'b1;
            end else begin
              mPred = sum[7:0];
            end
            if (mCnt != 16'hFFFF) mCnt = mCnt + 16'd1;
          end
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
          sendSample(rD, rS, rK, mk(mPred, mSat, mKe, mCnt));
        end
        stopToggle = 1'b1;
      end
      begin
        while (!stopToggle) begin
          @(posedge clk); #1;
          OutReady = ($urandom_range(0, 3) != 0);
        end
      end
    join
    OutReady = 1'b1;
    drain();
    checkVal("stream_count", popped - poppedStart, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
